// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if
// Bundles the operand handshake, the result handshake and the control
// strobes of the bit-serial subtractor controller.
//   in_valid/in_ready  : operand handshake (a, b, bin_init sampled on accept)
//   out_valid/out_ready: result handshake (diff, bout held until accepted)
//   busy               : controller is in RUN or DONE
//   clr                : synchronous abort back to IDLE
// Modports: master = requester/consumer side, slave = controller side.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin_init;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             clr;

    modport master (
        output in_valid, a, b, bin_init, out_ready, clr,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin_init, out_ready, clr,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtractor: diff = a - b - bin_init (mod 2^WIDTH), bout = final
// borrow. One full-subtract step per clock, LSB first, borrow kept in a flop.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_sub_ctrl_if.slave (operand/result handshakes, busy, clr)
// All outputs are registered; no combinational path from in_valid or
// out_ready to any output.
module serial_sub_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              rst,
    serial_sub_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sra_reg;
    logic [WIDTH-1:0] srb_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             brw_reg;
    logic             bout_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic             accept;
    logic             last_step;
    logic             d_bit;
    logic             nb_bit;

    // Next state and single-bit full-subtract step.
    always_comb begin
        d_bit      = sra_reg[0] ^ srb_reg[0] ^ brw_reg;
        nb_bit     = (~sra_reg[0] & srb_reg[0]) | (~(sra_reg[0] ^ srb_reg[0]) & brw_reg);
        // Decoding WIDTH-1 rather than relying on counter wrap keeps the
        // step count exact for non-power-of-2 widths.
        last_step  = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));
        accept     = 1'b0;
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid && in_ready_reg) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid_reg && bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over every transition, including an accept in IDLE.
        if (bus.clr) begin
            accept     = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sra_reg       <= '0;
            srb_reg       <= '0;
            diff_reg      <= '0;
            cnt_reg       <= '0;
            brw_reg       <= 1'b0;
            bout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            // Handshake flags are decoded from the next state so they line
            // up with the state register without extra latency.
            in_ready_reg  <= (state_next == IDLE);
            busy_reg      <= (state_next != IDLE);
            out_valid_reg <= (state_next == DONE);
            if (bus.clr) begin
                // diff is left as-is; it is meaningless while out_valid=0.
                bout_reg <= 1'b0;
            end else if (accept) begin
                sra_reg  <= bus.a;
                srb_reg  <= bus.b;
                brw_reg  <= bus.bin_init;
                cnt_reg  <= '0;
                diff_reg <= '0;
            end else if (state_reg == RUN) begin
                brw_reg  <= nb_bit;
                sra_reg  <= sra_reg >> 1;
                srb_reg  <= srb_reg >> 1;
                diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
                if (last_step) begin
                    bout_reg <= nb_bit;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller that computes diff = a - b - bin_init.
- Accepts an operand pair through a valid/ready handshake.
- Sequences one full-subtract step per clock, LSB first, holding the borrow in a flop between steps.
- Presents the WIDTH-bit difference and final borrow through a second valid/ready handshake.
- Sits between a requester and a result consumer wherever area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32
CW, $clog2(WIDTH), bit-counter width; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset; one clock domain
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  minuend; sampled on accept
b  input  WIDTH  subtrahend; sampled on accept
bin_init  input  1  initial borrow-in; sampled on accept
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin_init, modulo 2^WIDTH
bout  output  1  final borrow-out (1 = negative / underflow)
busy  output  1  high in RUN or DONE
clr  input  1  synchronous abort to IDLE; discards the operation

Behaviour:
- Reset is asynchronous and active-high; it applies immediately, mid-operation included. Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and counter are all 0.
- State machine IDLE, RUN, DONE; registered outputs only.
- IDLE: in_ready=1. On in_valid && in_ready at an edge:
  - sra<=a, srb<=b, brw<=bin_init, cnt<=0, diff<=0.
  - Go to RUN.
- RUN: in_ready=0, busy=1. Each edge:
  - d = sra[0]^srb[0]^brw.
  - nb = (~sra[0]&srb[0]) | (~(sra[0]^srb[0])&brw).
  - brw<=nb; sra, srb shift right by 1; diff<={d, diff[WIDTH-1:1]}; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: bout<=nb, out_valid<=1, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- Latency: accept at edge E; out_valid is high after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE: out_valid=1. diff and bout stay stable until the handshake.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE; no overlap of result hold with the next accept.
- in_valid while not in IDLE is ignored; operands are not captured.
- in_ready is 0 in RUN and DONE whatever in_valid does.
- clr has priority over all transitions in every state: next state IDLE, out_valid<=0, bout<=0.
  - diff keeps its last value; it is don't-care while out_valid=0.
  - clr in IDLE together with in_valid: no accept.
- bout=1 iff a < b + bin_init, unsigned.
- diff wraps modulo 2^WIDTH; no saturation.
- cnt must not wrap during RUN. The DONE transition is decoded from cnt==WIDTH-1, which stays correct for non-power-of-2 WIDTH.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin_init=0, out_ready=1 -> out_valid high 8 cycles after accept; diff=0x1E, bout=0; in_ready back to 1 one cycle after the result handshake.
2. a=0x00, b=0x01, bin_init=0 -> diff=0xFF, bout=1. Then a=0x00, b=0xFF, bin_init=1 -> diff=0x00, bout=1. Then a=0x10, b=0x0F, bin_init=1 -> diff=0x00, bout=0.
3. Backpressure: a=0xC8, b=0x64, out_ready=0 for 5 cycles after out_valid rises -> out_valid, diff=0x64 and bout=0 held constant all 5 cycles; a new in_valid with a=0xFF during DONE is not accepted (in_ready=0); after out_ready=1 the state returns to IDLE.
4. Reset mid-operation: assert rst asynchronously 3 cycles into RUN, between clock edges -> all outputs reach reset values immediately; after release, a=0x07, b=0x02 completes normally with diff=0x05, bout=0.
5. clr on the 4th RUN cycle -> IDLE next edge, out_valid never rises; the next operation a=0x80, b=0x01 gives diff=0x7F, bout=0.
6. Exhaustive/random sweep with WIDTH=5 (non-power-of-2) -> for all 32x32x2 input combinations, diff and bout match a reference model, and each RUN lasts exactly 5 cycles.
